// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key code, keymap and seven-segment definitions
package keypad_pkg;

  typedef logic [3:0] keycode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // History occupancy; the encoding doubles as the digit valid flags.
  typedef enum logic [1:0] {
    HIST_EMPTY = 2'b00,
    HIST_ONE   = 2'b01,
    HIST_TWO   = 2'b11
  } hist_state_t;

  typedef struct packed {
    logic     valid;
    keycode_t code;
  } key_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic key_t keymap(input logic [3:0] rows, input logic [3:0] col);
    key_t k;
    k.valid = onehot4(rows) && onehot4(col);
    case ({onehot_idx(rows), onehot_idx(col)})
      4'b00_00: k.code = 4'h1;
      4'b00_01: k.code = 4'h2;
      4'b00_10: k.code = 4'h3;
      4'b00_11: k.code = 4'hA;
      4'b01_00: k.code = 4'h4;
      4'b01_01: k.code = 4'h5;
      4'b01_10: k.code = 4'h6;
      4'b01_11: k.code = 4'hB;
      4'b10_00: k.code = 4'h7;
      4'b10_01: k.code = 4'h8;
      4'b10_10: k.code = 4'h9;
      4'b10_11: k.code = 4'hC;
      4'b11_00: k.code = 4'hE;
      4'b11_01: k.code = 4'h0;
      4'b11_10: k.code = 4'hF;
      default:  k.code = 4'hD;
    endcase
    return k;
  endfunction

  // Segment order {g,f,e,d,c,b,a}, active-low for a common-anode display.
  function automatic logic [6:0] seg7(input keycode_t code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h18;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex to active-low seven-segment decoder
module seg7_decoder
  import keypad_pkg::*;
(
  input  keycode_t   code_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = seg7(code_i);
  end

endmodule

// File: rtl/keypad_digit_display.sv
// rtl/keypad_digit_display.sv - keypad key capture into two-digit history, muxed 7-seg drive
module keypad_digit_display
  import keypad_pkg::*;
#(
  parameter int REFRESH_CNT = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] col,
  input  logic       num_new,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic [3:0] digit_r,
  output logic [3:0] digit_l,
  output logic [1:0] digit_vld
);

  localparam int CNT_W = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

  logic             num_new_q;
  logic             strobe;
  logic             capture;
  key_t             key;
  hist_state_t      state_q;
  keycode_t         digit_r_q;
  keycode_t         digit_l_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sel_q;
  logic             sel_d;
  keycode_t         disp_code;
  logic             disp_vld;
  logic [6:0]       disp_seg_n;
  logic [6:0]       seg_n_q;
  logic [1:0]       an_n_q;

  always_comb begin
    key       = keymap(rows, col);
    strobe    = num_new & ~num_new_q;
    capture   = strobe & key.valid;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    sel_d     = (cnt_q == CNT_LAST) ? ~sel_q : sel_q;
    disp_code = sel_q ? digit_l_q : digit_r_q;
    disp_vld  = sel_q ? state_q[1] : state_q[0];
  end

  seg7_decoder u_seg7 (
    .code_i  (disp_code),
    .seg_n_o (disp_seg_n)
  );

  // Output registers look at the current sel/history, so they trail both by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_new_q <= 1'b0;
      state_q   <= HIST_EMPTY;
      digit_r_q <= 4'h0;
      digit_l_q <= 4'h0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      an_n_q    <= 2'b11;
      seg_n_q   <= SEG_BLANK;
    end else begin
      num_new_q <= num_new;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      if (capture) begin
        digit_l_q <= digit_r_q;
        digit_r_q <= key.code;
        case (state_q)
          HIST_EMPTY: state_q <= HIST_ONE;
          HIST_ONE:   state_q <= HIST_TWO;
          HIST_TWO:   state_q <= HIST_TWO;
          default:    state_q <= HIST_EMPTY;
        endcase
      end
      an_n_q  <= sel_q ? 2'b01 : 2'b10;
      seg_n_q <= disp_vld ? disp_seg_n : SEG_BLANK;
    end
  end

  assign seg_n     = seg_n_q;
  assign an_n      = an_n_q;
  assign digit_r   = digit_r_q;
  assign digit_l   = digit_l_q;
  assign digit_vld = state_q;

endmodule
